// File: rtl/lru_tracker.sv
// Per-set true-LRU age tracker with registered victim lookup and a
// one-set-per-cycle flush sweep that restores every set to way 0 = LRU.
module lru_tracker #(
  parameter  int NUM_WAYS = 4,
  parameter  int NUM_SETS = 16,
  localparam int WW       = $clog2(NUM_WAYS),
  localparam int SW       = $clog2(NUM_SETS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          access_valid,
  input  logic [SW-1:0] access_set,
  input  logic [WW-1:0] access_way,
  input  logic          query_valid,
  input  logic [SW-1:0] query_set,
  output logic          victim_valid,
  output logic [WW-1:0] victim_way,
  input  logic          flush_req,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state_reg;
  logic [SW-1:0] cnt_reg;
  logic          busy_reg;
  logic          victim_valid_reg;
  logic [WW-1:0] victim_way_reg;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0][WW-1:0] ages_all;

  // Each set owns its ages; the whole array resets asynchronously, so it
  // lives in flops rather than block RAM.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SETS; gi++) begin : g_set
      logic [NUM_WAYS-1:0][WW-1:0] row_reg;
      logic                        hit;
      logic                        flush_wr;
      logic [WW-1:0]               old_age;

      assign hit      = access_valid && !busy_reg && (access_set == SW'(gi));
      assign flush_wr = busy_reg && (cnt_reg == SW'(gi));
      assign old_age  = row_reg[access_way];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int w = 0; w < NUM_WAYS; w++) row_reg[w] <= WW'(NUM_WAYS - 1 - w);
        end else if (flush_wr) begin
          for (int w = 0; w < NUM_WAYS; w++) row_reg[w] <= WW'(NUM_WAYS - 1 - w);
        end else if (hit) begin
          // Only ways younger than the touched one age; the permutation holds.
          for (int w = 0; w < NUM_WAYS; w++) begin
            if (WW'(w) == access_way)
              row_reg[w] <= '0;
            else if (row_reg[w] < old_age)
              row_reg[w] <= row_reg[w] + 1'b1;
          end
        end
      end

      assign ages_all[gi] = row_reg;
    end
  endgenerate

  logic [NUM_WAYS-1:0][WW-1:0] q_row;
  logic [WW-1:0]               lru_way;

  // Lookup reads pre-update state: no bypass from a same-edge access.
  always_comb begin
    q_row   = ages_all[query_set];
    lru_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (q_row[w] == WW'(NUM_WAYS - 1)) lru_way = WW'(w);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      busy_reg         <= 1'b0;
      victim_valid_reg <= 1'b0;
      victim_way_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush_req) begin
            state_reg <= FLUSH;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        FLUSH: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == SW'(NUM_SETS - 1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (query_valid && !busy_reg) begin
        victim_valid_reg <= 1'b1;
        victim_way_reg   <= lru_way;
      end else begin
        victim_valid_reg <= 1'b0;
      end
    end
  end

  assign victim_valid = victim_valid_reg;
  assign victim_way   = victim_way_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_lru_tracker.sv
// Randomized + directed bench for lru_tracker; the reference keeps a
// recency-ordered list per set (front = most recent, back = victim).
module tb_lru_tracker;

  localparam int NW = 4;
  localparam int NS = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       access_valid = 1'b0;
  logic [3:0] access_set = '0;
  logic [1:0] access_way = '0;
  logic       query_valid = 1'b0;
  logic [3:0] query_set = '0;
  logic       victim_valid;
  logic [1:0] victim_way;
  logic       flush_req = 1'b0;
  logic       busy;

  lru_tracker #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clock        (clock),
    .reset        (reset),
    .access_valid (access_valid),
    .access_set   (access_set),
    .access_way   (access_way),
    .query_valid  (query_valid),
    .query_set    (query_set),
    .victim_valid (victim_valid),
    .victim_way   (victim_way),
    .flush_req    (flush_req),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_vw;

  int order [NS][$];
  bit m_busy;
  int m_cnt;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void init_set(input int s);
    order[s].delete();
    for (int w = 0; w < NW; w++) order[s].push_front(w);
  endfunction

  function automatic int lru(input int s);
    return order[s][order[s].size() - 1];
  endfunction

  function automatic void touch(input int s, input int w);
    for (int i = 0; i < order[s].size(); i++) begin
      if (order[s][i] == w) begin
        order[s].delete(i);
        break;
      end
    end
    order[s].push_front(w);
  endfunction

  task automatic do_cycle(input bit av, input int as, input int aw,
                          input bit qv, input int qs, input bit fr);
    bit exp_vv;
    int exp_vw;
    exp_vv = qv && !m_busy;
    exp_vw = exp_vv ? lru(qs) : 0;
    access_valid = av;  access_set = 4'(as);  access_way = 2'(aw);
    query_valid  = qv;  query_set  = 4'(qs);  flush_req  = fr;
    @(posedge clock); #1;
    cyc++;
    if (m_busy) begin
      init_set(m_cnt);
      m_cnt++;
      if (m_cnt == NS) begin m_busy = 0; m_cnt = 0; end
    end else begin
      if (av) touch(as, aw);
      if (fr) begin m_busy = 1; m_cnt = 0; end
    end
    $display("cyc %0d acc=%0b s%0d w%0d qry=%0b s%0d fl=%0b -> vv=%0b vw=%0d busy=%0b",
             cyc, av, as, aw, qv, qs, fr, victim_valid, victim_way, busy);
    check("victim_valid", int'(victim_valid), int'(exp_vv));
    if (exp_vv) begin
      check("victim_way", int'(victim_way), exp_vw);
      last_vw = int'(victim_way);
    end
    check("busy", int'(busy), int'(m_busy));
    access_valid = 0; query_valid = 0; flush_req = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_victim_valid", int'(victim_valid), 0);
    check("rst_victim_way", int'(victim_way), 0);
    for (int s = 0; s < NS; s++) init_set(s);
    m_busy = 0;
    m_cnt  = 0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    apply_reset();

    // Fresh reset: way 0 is the victim.
    do_cycle(0, 0, 0, 1, 3, 0);
    check("req031_vw", last_vw, 0);

    // Set 5: touch way 0, then 1..3.
    do_cycle(1, 5, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 5, 0);
    check("req032_a", last_vw, 1);
    for (int w = 1; w < NW; w++) do_cycle(1, 5, w, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 5, 0);
    check("req032_b", last_vw, 0);

    // Same-edge access and query sees the old state.
    do_cycle(1, 7, 2, 1, 7, 0);
    check("req033_a", last_vw, 0);
    do_cycle(0, 0, 0, 1, 7, 0);
    check("req033_b", last_vw, 0);
    do_cycle(1, 7, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 7, 0);
    check("req033_c", last_vw, 1);

    // Flush with traffic dropped while busy.
    for (int i = 0; i < 6; i++) do_cycle(1, $urandom_range(0, NS-1), $urandom_range(0, NW-1), 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < NS; i++)
      do_cycle(1, $urandom_range(0, NS-1), $urandom_range(0, NW-1), 1, $urandom_range(0, NS-1), 1);
    for (int s = 0; s < NS; s++) begin
      do_cycle(0, 0, 0, 1, s, 0);
      check("req034_flushed", last_vw, 0);
    end

    // Reset in the middle of a sweep.
    do_cycle(1, 9, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 0, 0, 0);
    apply_reset();
    do_cycle(0, 0, 0, 1, 9, 0);
    check("req035_set9", last_vw, 0);
    do_cycle(0, 0, 0, 1, 12, 0);
    check("req035_set12", last_vw, 0);
    do_cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < NS; i++) do_cycle(0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0);

    // Random traffic against the recency-list model.
    for (int i = 0; i < 1000; i++) begin
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, NS-1), $urandom_range(0, NW-1),
               $urandom_range(0, 1) == 1, $urandom_range(0, NS-1),
               $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < NS; i++) do_cycle(0, 0, 0, 0, 0, 0);
    for (int s = 0; s < NS; s++) do_cycle(0, 0, 0, 1, s, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
